// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer and its step datapath.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_ITER = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    // Wide enough for any WIDTH up to 64; users slice the low WIDTH bits.
    localparam logic [63:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EXE stage and the multiply/divide sequencer.
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
);
    // start/op/a/b form a single-cycle request, taken only when the sequencer is idle;
    // there is no ready: while busy (=stall) is high the pipeline holds and the request
    // is re-presented after done. flush squashes the request or the in-flight op.
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    md_state_e        state_dbg;

    modport master (
        output start, op, a, b, flush,
        input  stall, busy, done, hi, lo, state_dbg
    );

    modport slave (
        input  start, op, a, b, flush,
        output stall, busy, done, hi, lo, state_dbg
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: shift-add multiply or restoring divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    // Divide:   acc = {partial remainder, remaining dividend / quotient bits}, shifted left.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, opnd};
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MIPS multiply/divide sequencer owning the HI/LO registers.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    rst_b,
    muldiv_if.slave md
);

    localparam int CW = $clog2(WIDTH);

    md_state_e          state;
    md_state_e          state_nxt;
    md_op_e             op_e;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_raw;
    logic               neg_q;
    logic               neg_r;
    logic               div0;
    logic               is_div;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               req;
    logic               load;
    logic               req_signed;
    logic               req_div;
    logic               mt_hi;
    logic               mt_lo;
    logic               step_en;
    logic               fix_wr;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_new;
    logic [WIDTH-1:0]   lo_new;

    assign op_e = md_op_e'(md.op);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (load) state_nxt = MD_ITER;
            MD_ITER: begin
                if (md.flush) begin
                    state_nxt = MD_IDLE;
                end else if (count == CW'(WIDTH - 1)) begin
                    state_nxt = MD_FIX;
                end
            end
            MD_FIX:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_comb begin
        req        = (state == MD_IDLE) && md.start && !md.flush;
        req_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
        req_div    = (op_e == MD_DIV) || (op_e == MD_DIVU);
        load       = req && (req_signed || req_div || (op_e == MD_MULTU));
        mt_hi      = req && (op_e == MD_MTHI);
        mt_lo      = req && (op_e == MD_MTLO);
        step_en    = (state == MD_ITER) && !md.flush;
        fix_wr     = (state == MD_FIX) && !md.flush;
    end

    assign a_mag = (req_signed && md.a[WIDTH-1]) ? -md.a : md.a;
    assign b_mag = (req_signed && md.b[WIDTH-1]) ? -md.b : md.b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .opnd     (opnd),
        .is_div   (is_div),
        .acc_next (acc_step)
    );

    // Sign fix on the magnitude result; divide-by-zero overrides it with fixed values.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
        hi_new   = prod_fix[2*WIDTH-1:WIDTH];
        lo_new   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (div0) begin
                hi_new = a_raw;
                lo_new = DIV0_LO[WIDTH-1:0];
            end else begin
                hi_new = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                lo_new = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            is_div <= 1'b0;
        end else if (load) begin
            count  <= '0;
            acc    <= {{WIDTH{1'b0}}, (req_div ? a_mag : b_mag)};
            opnd   <= req_div ? b_mag : a_mag;
            a_raw  <= md.a;
            neg_q  <= req_signed && (md.a[WIDTH-1] ^ md.b[WIDTH-1]);
            neg_r  <= req_signed && md.a[WIDTH-1];
            div0   <= req_div && (md.b == '0);
            is_div <= req_div;
        end else if (step_en) begin
            count <= count + 1'b1;
            acc   <= acc_step;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt != MD_IDLE);
            done_q <= fix_wr;
            if (fix_wr) begin
                hi_q <= hi_new;
                lo_q <= lo_new;
            end else begin
                if (mt_hi) hi_q <= md.a;
                if (mt_lo) lo_q <= md.a;
            end
        end
    end

    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
    assign md.busy      = busy_q;
    assign md.stall     = busy_q;
    assign md.done      = done_q;
    assign md.state_dbg = state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed and randomized checks of muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_b;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) md ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .md    (md)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            default: return 64'd0;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        md.start = 1'b1;
        md.op    = op;
        md.a     = a;
        md.b     = b;
        @(negedge clk);
        md.start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        int s = 0;
        busy_cnt = 0;
        while (!md.done && s < 60) begin
            busy_cnt += int'(md.busy);
            @(negedge clk);
            s++;
        end
        lat = md.done ? s : -1;
        if (lat < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int          lat, bc;
        logic [63:0] e;
        issue(op, a, b);
        wait_done(lat, bc);
        e = exp_q.pop_front();
        if (lat >= 0) begin
            chk({tag, "_latency"}, 64'(lat), 64'd33);
            chk({tag, "_busy_cycles"}, 64'(bc), 64'd33);
            chk(tag, {md.hi, md.lo}, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat, bc, dcnt;
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] e;

        rst_b    = 1'b0;
        md.start = 1'b0;
        md.op    = 3'd0;
        md.a     = '0;
        md.b     = '0;
        md.flush = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hilo", {md.hi, md.lo}, 64'd0);
        chk("reset_busy_done", {62'd0, md.busy, md.done}, 64'd0);
        chk("reset_state", 64'(md.state_dbg), 64'(MD_IDLE));
        rst_b = 1'b1;
        @(negedge clk);

        exp_q.push_back(64'hFFFF_FFFE_0000_0001);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'd7, "mult_neg3x7");
        exp_q.push_back(64'h4000_0000_0000_0000);
        run_op(MD_MULT, 32'h8000_0000, 32'h8000_0000, "mult_minxmin");
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
        exp_q.push_back(64'h0000_0001_0000_0003);
        run_op(MD_DIVU, 32'd7, 32'd2, "divu_7by2");
        exp_q.push_back(64'h0000_000F_0FFF_FFFF);
        run_op(MD_DIVU, 32'hFFFF_FFFF, 32'h10, "divu_max_by16");
        exp_q.push_back(64'h1234_5678_FFFF_FFFF);
        run_op(MD_DIV, 32'h1234_5678, 32'd0, "div_by_zero");
        exp_q.push_back(64'h0000_0000_8000_0000);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");

        // MTHI then MTLO on consecutive cycles
        md.start = 1'b1; md.op = MD_MTHI; md.a = 32'h11;
        @(negedge clk);
        chk("mthi_hi", 64'(md.hi), 64'h11);
        chk("mthi_busy_done", {62'd0, md.busy, md.done}, 64'd0);
        md.op = MD_MTLO;
        @(negedge clk);
        md.start = 1'b0;
        chk("mtlo_hilo", {md.hi, md.lo}, 64'h0000_0011_0000_0011);
        chk("mtlo_busy", 64'(md.busy), 64'd0);

        // flush at the 10th ITER cycle
        issue(MD_DIVU, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        md.flush = 1'b1;
        @(negedge clk);
        md.flush = 1'b0;
        chk("flush_busy", 64'(md.busy), 64'd0);
        chk("flush_hilo", {md.hi, md.lo}, 64'h0000_0011_0000_0011);
        dcnt = 0;
        repeat (40) begin
            dcnt += int'(md.done);
            @(negedge clk);
        end
        chk("flush_no_done", 64'(dcnt), 64'd0);
        chk("flush_hilo_late", {md.hi, md.lo}, 64'h0000_0011_0000_0011);

        // flush in IDLE cancels a same-cycle MTHI and a same-cycle DIVU
        md.flush = 1'b1;
        issue(MD_MTHI, 32'h55, 32'd0);
        chk("idle_flush_mthi", 64'(md.hi), 64'h11);
        issue(MD_DIVU, 32'd9, 32'd2);
        md.flush = 1'b0;
        chk("idle_flush_div_busy", 64'(md.busy), 64'd0);

        // ops 6/7 have no effect
        issue(3'd6, 32'h77, 32'h1);
        issue(3'd7, 32'h78, 32'h1);
        chk("noop_hilo", {md.hi, md.lo}, 64'h0000_0011_0000_0011);
        chk("noop_busy", 64'(md.busy), 64'd0);

        // start while busy is ignored
        issue(MD_MULTU, 32'd5, 32'd6);
        repeat (3) @(negedge clk);
        issue(MD_MTLO, 32'h99, 32'd0);
        chk("busy_start_ignored", 64'(md.lo), 64'h11);
        wait_done(lat, bc);
        if (lat >= 0) begin
            chk("busy_start_latency", 64'(lat), 64'd29);
            chk("busy_start_result", {md.hi, md.lo}, 64'd30);
        end

        // asynchronous reset mid-MULT
        @(negedge clk);
        issue(MD_MULT, 32'd3, 32'd4);
        repeat (10) @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        chk("async_rst_hilo", {md.hi, md.lo}, 64'd0);
        chk("async_rst_busy_done", {62'd0, md.busy, md.done}, 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        // back-to-back: second start lands in the done cycle of the first
        exp_q.push_back(64'd391);
        run_op(MD_MULTU, 32'd17, 32'd23, "b2b_first");
        exp_q.push_back(64'h0000_0004_0000_0010);
        run_op(MD_DIVU, 32'd100, 32'd6, "b2b_second");

        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            e = ref_model(rop, ra, rb);
            exp_q.push_back(e);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
        end

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
